// File: rtl/neuron_mac_sequencer_pkg.sv
// Fixed-point helpers and FSM encoding shared by the neuron MAC sequencer.
// Values on the datapath are Q5.10 sign-magnitude; the accumulator is two's complement.
package nn_fixed_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
  localparam int INT_W  = 5;
  localparam int ADDR_W = 6;
  localparam int ACC_W  = DATA_W + ADDR_W + 1;
  localparam logic [15:0] MAG_MAX = 16'h7FFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RUN,
    ACCUM,
    SAT,
    OUT
  } state_t;

  function automatic logic signed [31:0] sm_to_tc(input logic [15:0] sm);
    logic signed [31:0] mag;
    mag = {17'd0, sm[14:0]};
    return sm[15] ? -mag : mag;
  endfunction

  // Returns {sat_flag, sign-magnitude}; zero never comes back as negative zero.
  function automatic logic [16:0] tc_to_sm_sat(input logic signed [31:0] tc);
    logic        neg;
    logic [31:0] mag;
    neg = tc[31];
    mag = neg ? 32'(-tc) : 32'(tc);
    if (mag > {16'd0, MAG_MAX}) begin
      return {1'b1, neg, MAG_MAX[14:0]};
    end
    return {1'b0, neg, mag[14:0]};
  endfunction

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Memory, multiplier and result-handshake signals of the neuron MAC sequencer.
interface neuron_mac_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] w_data;
  logic              mult_enable;
  logic              mult_weight_bit;
  logic [DATA_W-1:0] mult_neuron;
  logic [DATA_W-1:0] mult_out;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_ready;
  logic              overflow;

  modport master (
    output mem_addr, mult_enable, mult_weight_bit, mult_neuron,
           result, result_valid, overflow,
    input  in_data, w_data, mult_out, result_ready
  );

  modport slave (
    input  mem_addr, mult_enable, mult_weight_bit, mult_neuron,
           result, result_valid, overflow,
    output in_data, w_data, mult_out, result_ready
  );

endinterface

// File: rtl/neuron_mac_sequencer_weight_serializer.sv
// Streams a sign-magnitude weight into the bit-serial multiplier: magnitude MSB
// first for bit slots 0..14, the sign at slot 15, zeros until the capture slot.
module weight_serializer #(
  parameter int DATA_W         = 16,
  parameter int CAPTURE_OFFSET = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] weight,
  output logic              weight_bit,
  output logic              done
);

  localparam int K_W = $clog2(CAPTURE_OFFSET + 1);

  logic [K_W-1:0]    k;
  logic [DATA_W-2:0] mag_shift;
  logic              sign;

  always_ff @(posedge clk) begin
    if (!reset) begin
      k         <= '0;
      mag_shift <= '0;
      sign      <= 1'b0;
    end else if (load) begin
      k         <= '0;
      mag_shift <= weight[DATA_W-2:0];
      sign      <= weight[DATA_W-1];
    end else if (advance && !done) begin
      k         <= k + K_W'(1);
      mag_shift <= mag_shift << 1;
    end
  end

  always_comb begin
    weight_bit = 1'b0;
    if (k < K_W'(DATA_W - 1)) begin
      weight_bit = mag_shift[DATA_W-2];
    end else if (k == K_W'(DATA_W - 1)) begin
      weight_bit = sign;
    end
  end

  assign done = (k == K_W'(CAPTURE_OFFSET));

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Sequences one bit-serial multiplier over N input/weight pairs and accumulates
// bias + sum(x*w), delivering a saturated Q5.10 sign-magnitude result.
module neuron_mac_sequencer
  import nn_fixed_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 6,
  parameter int CAPTURE_OFFSET = 17,
  parameter int ACC_W          = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W:0]        num_inputs,
  input  logic [DATA_W-1:0]      bias,
  output logic                   busy,
  neuron_mac_sequencer_if.master bus
);

  localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t                   state;
  state_t                   next_state;
  logic [ADDR_W:0]          n_reg;
  logic [ADDR_W:0]          idx;
  logic [ADDR_W:0]          idx_next;
  logic [ADDR_W:0]          n_clamped;
  logic [DATA_W-1:0]        prod_reg;
  logic signed [ACC_W-1:0]  acc;
  logic                     ser_bit;
  logic                     ser_done;
  logic                     sat_flag;
  logic [DATA_W-1:0]        sat_sm;

  assign n_clamped        = (num_inputs > N_MAX) ? N_MAX : num_inputs;
  assign idx_next         = idx + (ADDR_W+1)'(1);
  assign bus.mem_addr     = idx[ADDR_W-1:0];
  assign {sat_flag, sat_sm} = tc_to_sm_sat(32'(acc));

  weight_serializer #(
    .DATA_W         (DATA_W),
    .CAPTURE_OFFSET (CAPTURE_OFFSET)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .load       (state == LOAD),
    .advance    (state == RUN),
    .weight     (bus.w_data),
    .weight_bit (ser_bit),
    .done       (ser_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      n_reg           <= '0;
      idx             <= '0;
      acc             <= '0;
      prod_reg        <= '0;
      bus.mult_neuron <= '0;
      bus.result      <= '0;
      bus.overflow    <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            n_reg        <= n_clamped;
            idx          <= '0;
            acc          <= ACC_W'(sm_to_tc(bias));
            bus.overflow <= 1'b0;
          end
        end
        LOAD:  bus.mult_neuron <= bus.in_data;
        RUN: begin
          if (ser_done) begin
            prod_reg <= bus.mult_out;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(sm_to_tc(prod_reg));
          idx <= idx_next;
        end
        SAT: begin
          bus.result   <= sat_sm;
          bus.overflow <= sat_flag;
        end
        default: ;
      endcase
    end
  end

  // Enable is low in ACCUM/FETCH/LOAD, giving the multiplier a gap to realign.
  always_comb begin
    next_state          = state;
    busy                = 1'b1;
    bus.result_valid    = 1'b0;
    bus.mult_enable     = 1'b0;
    bus.mult_weight_bit = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = (n_clamped != '0) ? FETCH : SAT;
        end
      end
      FETCH: next_state = LOAD;
      LOAD:  next_state = RUN;
      RUN: begin
        bus.mult_enable     = 1'b1;
        bus.mult_weight_bit = ser_bit;
        if (ser_done) begin
          next_state = ACCUM;
        end
      end
      ACCUM: next_state = (idx_next < n_reg) ? FETCH : SAT;
      SAT:   next_state = OUT;
      OUT: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer with RAM and bit-serial multiplier models
// and a scoreboard of expected results.
module tb_neuron_mac_sequencer;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  num_inputs = '0;
  logic [15:0] bias = '0;
  logic        busy;

  logic [15:0] in_mem [64];
  logic [15:0] w_mem  [64];

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int          mcnt = 0;
  int          en_count = 0;
  int          extra_ones = 0;
  logic [15:0] wrec = '0;
  logic [15:0] last_w = '0;
  logic [15:0] last_x = '0;

  neuron_mac_sequencer_if #(.DATA_W(16), .ADDR_W(6)) bus();

  neuron_mac_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_inputs (num_inputs),
    .bias       (bias),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.in_data <= in_mem[bus.mem_addr];
    bus.w_data  <= w_mem[bus.mem_addr];
  end

  function automatic logic [15:0] mul_model(input logic [15:0] x, input logic [15:0] w);
    logic [29:0] p;
    logic [19:0] m;
    p = 30'(x[14:0]) * 30'(w[14:0]);
    m = p[29:10];
    if (m > 20'h7FFF) m = 20'h7FFF;
    if (m == 20'd0) return 16'h0000;
    return {x[15] ^ w[15], m[14:0]};
  endfunction

  // Rebuild the weight from the serial stream and answer with the product.
  always @(negedge clk) begin
    if (bus.mult_enable) begin
      if (mcnt == 0) last_x = bus.mult_neuron;
      if (mcnt < 15) begin
        wrec[14-mcnt] = bus.mult_weight_bit;
      end else if (mcnt == 15) begin
        wrec[15]     = bus.mult_weight_bit;
        last_w       = wrec;
        bus.mult_out = mul_model(bus.mult_neuron, wrec);
      end else if (bus.mult_weight_bit) begin
        extra_ones++;
      end
      mcnt++;
      en_count++;
    end else begin
      mcnt         = 0;
      bus.mult_out = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] n, input logic [15:0] b,
                               input logic [15:0] exp_res, input logic exp_ovf, input int lat);
    exp_t e;
    e.res = exp_res;
    e.ovf = exp_ovf;
    e.lat = lat;
    sb_q.push_back(e);
    num_inputs = n;
    bias       = b;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int hold, input bit pulse);
    exp_t e;
    int   cycles;
    e = sb_q.pop_front();
    cycles = 1;
    while (!bus.result_valid && cycles < 3000) begin
      step();
      cycles++;
    end
    chk({tag, "_latency"}, cycles, e.lat);
    chk({tag, "_result"}, bus.result, e.res);
    chk({tag, "_overflow"}, bus.overflow, e.ovf);
    chk({tag, "_busy_in_out"}, busy, 1'b1);
    for (int h = 0; h < hold; h++) begin
      if (pulse && h == 0) begin
        num_inputs = 7'd0;
        bias       = 16'h0400;
        start      = 1'b1;
      end
      step();
      start = 1'b0;
      chk({tag, "_hold_result"}, bus.result, e.res);
      chk({tag, "_hold_valid"}, bus.result_valid, 1'b1);
    end
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_valid_after"}, bus.result_valid, 1'b0);
  endtask

  initial begin
    int base;
    int cycles;
    for (int a = 0; a < 64; a++) begin
      in_mem[a] = 16'h0000;
      w_mem[a]  = 16'h0000;
    end
    bus.result_ready = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", bus.result_valid, 1'b0);
    chk("rst_enable", bus.mult_enable, 1'b0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_neuron", bus.mult_neuron, 16'h0000);
    reset = 1'b1;
    step();

    $display("[TB] single pair 2.0 * 1.5");
    in_mem[0] = 16'h0800; w_mem[0] = 16'h0600;
    base = extra_ones;
    applyStimulus(7'd1, 16'h0000, 16'h0C00, 1'b0, 23);
    checkOutput("t1", 0, 1'b0);
    chk("t1_weight_stream", last_w, 16'h0600);
    chk("t1_tail_bits", extra_ones - base, 0);
    chk("t1_neuron", last_x, 16'h0800);

    $display("[TB] negative weight with bias");
    in_mem[0] = 16'h0400; w_mem[0] = 16'h8600;
    applyStimulus(7'd1, 16'h0200, 16'h8400, 1'b0, 23);
    checkOutput("t2", 0, 1'b0);
    chk("t2_weight_stream", last_w, 16'h8600);

    $display("[TB] saturation over four pairs");
    for (int a = 0; a < 4; a++) begin
      in_mem[a] = 16'h7C00; w_mem[a] = 16'h0400;
    end
    applyStimulus(7'd4, 16'h0000, 16'h7FFF, 1'b1, 86);
    checkOutput("t3", 0, 1'b0);

    $display("[TB] empty job with negative-zero bias");
    base = en_count;
    applyStimulus(7'd0, 16'h8000, 16'h0000, 1'b0, 2);
    checkOutput("t4", 0, 1'b0);
    chk("t4_no_enable", en_count - base, 0);

    $display("[TB] backpressure and ignored start");
    in_mem[0] = 16'h0400; w_mem[0] = 16'h0400;
    in_mem[1] = 16'h0800; w_mem[1] = 16'h0400;
    in_mem[2] = 16'h0C00; w_mem[2] = 16'h0400;
    applyStimulus(7'd3, 16'h0000, 16'h1800, 1'b0, 65);
    checkOutput("t5", 5, 1'b1);
    repeat (3) step();
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_valid", bus.result_valid, 1'b0);
    chk("t5_retained", bus.result, 16'h1800);

    $display("[TB] reset in the middle of RUN");
    in_mem[0] = 16'h0800; w_mem[0] = 16'h0600;
    num_inputs = 7'd1;
    bias       = 16'h0000;
    start      = 1'b1;
    step();
    start  = 1'b0;
    cycles = 0;
    while (!bus.mult_enable && cycles < 100) begin
      step();
      cycles++;
    end
    chk("t6_run_reached", bus.mult_enable, 1'b1);
    repeat (8) step();
    reset = 1'b0;
    step();
    chk("t6_busy", busy, 1'b0);
    chk("t6_enable", bus.mult_enable, 1'b0);
    chk("t6_wbit", bus.mult_weight_bit, 1'b0);
    chk("t6_result", bus.result, 16'h0000);
    chk("t6_valid", bus.result_valid, 1'b0);
    chk("t6_neuron", bus.mult_neuron, 16'h0000);
    chk("t6_addr", bus.mem_addr, 6'd0);
    reset = 1'b1;
    step();
    applyStimulus(7'd1, 16'h0000, 16'h0C00, 1'b0, 23);
    checkOutput("t6_fresh", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
